dff_mem_arbiter: RTL and testbench
==================================

Name: dff_mem_arbiter

Overview:
- Shares one 16x8 DFF memory (addr/data_in/data_out/lr_n/ce_n interface) between two requester ports, A and B.
- Arbitrates round-robin and sequences each access through a fixed 3-state access cycle.
- Returns read data with a one-cycle response strobe.
- Provides a hardware clear sequence that zero-fills every location, so software can clear memory without issuing 16 writes.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory data width.
- DEPTH, 16, number of memory locations swept by the clear sequence; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A request valid.
- a_ready  out  1  requester A request accepted this cycle.
- a_we  in  1  1=write, 0=read.
- a_addr  in  ADDR_W  request address.
- a_wdata  in  DATA_W  write data.
- a_rsp_valid  out  1  one-cycle response strobe to A.
- a_rsp_rdata  out  DATA_W  read data to A; 0 for writes.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rsp_valid, b_rsp_rdata: same as the A signals, for requester B.
- init_start  in  1  pulse to start the clear sweep.
- init_done  out  1  one-cycle pulse when the sweep completes.
- busy  out  1  high whenever the state is not IDLE.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_rdata  in  DATA_W  from memory data_out; valid only while mem_ce_n=0.
- mem_lr_n  out  1  active-low write enable to memory.
- mem_ce_n  out  1  active-low read enable to memory.

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values:
  - State = IDLE; last_grant = B, so A wins the first tie.
  - mem_lr_n=1, mem_ce_n=1, mem_addr=0, mem_wdata=0.
  - a_ready=b_ready=0, rsp_valid both 0, rsp_rdata both 0, busy=0, init_done=0.
- Reset mid-access or mid-sweep aborts immediately. No response or init_done is issued. Memory contents are left as written so far.
- States: IDLE, ACCESS, RESP, INIT.
- IDLE:
  - init_start has priority over requests. If init_start=1, go to INIT with sweep counter=0. No ready is asserted that cycle.
  - Otherwise, x_ready is asserted combinationally for the arbitration winner only, and only when that requester's valid=1.
  - Handshake = valid & ready. On handshake, latch we/addr/wdata and the owner ID, update last_grant to the owner, and go to ACCESS.
  - Arbitration: if both are valid, grant the port opposite last_grant. If only one is valid, grant it. last_grant is unchanged when there is no grant.
- ACCESS (1 cycle): drive mem_addr from the latched address.
  - Write: mem_lr_n=0 and mem_wdata=latched data; memory captures at the closing edge.
  - Read: mem_ce_n=0; mem_rdata is registered into the owner's rsp_rdata at the closing edge.
  - Next state: RESP.
- RESP (1 cycle): owner's rsp_valid=1 with rsp_rdata held. A write response carries rdata=0. Next state: IDLE.
  - rsp_rdata holds its value until that port's next response.
  - The non-owner's rsp_valid stays 0.
- Latency and throughput: a handshake at edge T gives rsp_valid high during cycle T+2. Peak throughput is one access per 3 cycles.
- A request held valid across RESP is arbitrated again on return to IDLE. With both ports saturated, grants alternate A, B, A, ...
- INIT: for counter 0..DEPTH-1, one location per cycle: mem_addr=counter, mem_wdata=0, mem_lr_n=0.
  - After the write of DEPTH-1, pulse init_done for one cycle and return to IDLE. The counter wraps to 0 and does not restart the sweep.
  - Both ready outputs stay 0 throughout INIT.
  - init_start outside IDLE is ignored and is not queued.
- mem_lr_n and mem_ce_n are never both 0. Both are 1 in IDLE and RESP.
- busy = (state != IDLE).
- Requester inputs may change freely while ready=0; they are sampled only at handshake.

Decomposition:
- Shared package dff_mem_pkg holds:
  - ADDR_W and DATA_W defaults and DEPTH.
  - The state enum: IDLE, ACCESS, RESP, INIT.
  - Owner ID constants OWN_A and OWN_B.
- One natural sub-module, rr_arb2: inputs req[1:0] and last_grant; outputs a one-hot gnt[1:0]. It is purely combinational; the top-level register is the only state for last_grant.

Test Plan:
- After reset, A writes 0x5A to addr 3, then A reads addr 3 -> a_ready at first edge; a_rsp_valid 2 cycles later; read response gives a_rsp_rdata=0x5A; mem_lr_n and mem_ce_n never both 0.
- A and B both held valid with reads of addr 1 and addr 2 for 12 cycles -> grant order A, B, A, B; one rsp_valid every 3 cycles, each on the correct port with the correct data.
- Write 0xFF to all 16 addresses, pulse init_start in IDLE -> busy for 16 cycles with mem_addr stepping 0..15 and mem_lr_n=0; init_done pulses once; all subsequent reads return 0x00.
- init_start pulsed during ACCESS, and a_valid held during INIT -> init_start is ignored; a_ready stays 0 until INIT ends and is then granted in IDLE.
- rst asserted during ACCESS of a write to addr 7 (old value 0x11), and separately during INIT at counter 5 -> next cycle all outputs are at reset values, no rsp_valid and no init_done; addr 7 is either unchanged or fully written with no partial value.
- init_start and a_valid asserted in the same IDLE cycle -> INIT entered; a_ready=0 that cycle.

Source files
------------

// File: rtl/dff_mem_pkg.sv
// Shared definitions for the DFF memory arbiter slice.
// Holds the default memory geometry, the access-sequencer state encoding
// and the requester owner IDs used by the top level and the arbiter.
package dff_mem_pkg;

    localparam int DFLT_ADDR_W = 4;
    localparam int DFLT_DATA_W = 8;
    localparam int DFLT_DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        INIT   = 2'd3
    } state_t;

    // Owner / last-grant encoding: bit index into req/gnt vectors.
    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req[1:0]    request vector, bit 0 = A, bit 1 = B
//   last_grant  owner of the most recent grant (OWN_A / OWN_B)
//   gnt[1:0]    one-hot grant (all zero when nothing requests)
module rr_arb2
    import dff_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // On a tie the port that did not win last time is served.
        if (req == 2'b11) begin
            gnt = (last_grant == OWN_A) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dff_mem_arbiter.sv
// Shares one DFF memory between requester ports A and B.
// Each granted request runs IDLE -> ACCESS -> RESP; a hardware clear sweep
// (INIT) zero-fills every location, one per cycle.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   a_* / b_*                  requester valid/ready/we/addr/wdata and
//                              one-cycle response strobe with read data
//   init_start / init_done     start clear sweep / one-cycle completion pulse
//   busy                       state is not IDLE
//   mem_addr/mem_wdata/mem_rdata/mem_lr_n/mem_ce_n  memory interface
module dff_mem_arbiter
    import dff_mem_pkg::*;
#(
    parameter int ADDR_W = DFLT_ADDR_W,
    parameter int DATA_W = DFLT_DATA_W,
    parameter int DEPTH  = DFLT_DEPTH
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,
    input  logic              init_start,
    output logic              init_done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_lr_n,
    output logic              mem_ce_n
);

    localparam logic [ADDR_W-1:0] LAST_LOC = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nx;
    logic              last_grant;
    logic              owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [ADDR_W-1:0] cnt;
    logic              init_done_q;
    logic [1:0]        gnt;
    logic [DATA_W-1:0] access_rdata;

    rr_arb2 u_arb (
        .req        ({b_valid, a_valid}),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    // Ready only in IDLE, and init_start pre-empts any grant that cycle.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state == IDLE && !init_start) begin
            a_ready = gnt[0];
            b_ready = gnt[1];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (init_start) begin
                    state_nx = INIT;
                end else if (a_ready || b_ready) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            INIT:    if (cnt == LAST_LOC) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Write responses report zero; reads report what memory drives now.
    assign access_rdata = lat_we ? '0 : mem_rdata;

    // Request latch, arbitration history, sweep counter, response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= OWN_B;
            owner       <= OWN_A;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            cnt         <= '0;
            a_rsp_rdata <= '0;
            b_rsp_rdata <= '0;
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= (state == INIT) && (cnt == LAST_LOC);
            case (state)
                IDLE: begin
                    if (init_start) begin
                        cnt <= '0;
                    end else if (a_ready || b_ready) begin
                        owner      <= b_ready ? OWN_B : OWN_A;
                        last_grant <= b_ready ? OWN_B : OWN_A;
                        lat_we     <= b_ready ? b_we    : a_we;
                        lat_addr   <= b_ready ? b_addr  : a_addr;
                        lat_wdata  <= b_ready ? b_wdata : a_wdata;
                    end
                end
                ACCESS: begin
                    if (owner == OWN_A) begin
                        a_rsp_rdata <= access_rdata;
                    end else begin
                        b_rsp_rdata <= access_rdata;
                    end
                end
                INIT: begin
                    cnt <= (cnt == LAST_LOC) ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output logic: memory strobes and response strobes decode from state.
    always_comb begin
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_lr_n    = 1'b1;
        mem_ce_n    = 1'b1;
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        case (state)
            ACCESS: begin
                mem_addr = lat_addr;
                if (lat_we) begin
                    mem_lr_n  = 1'b0;
                    mem_wdata = lat_wdata;
                end else begin
                    mem_ce_n  = 1'b0;
                end
            end
            RESP: begin
                a_rsp_valid = (owner == OWN_A);
                b_rsp_valid = (owner == OWN_B);
            end
            INIT: begin
                mem_addr = cnt;
                mem_lr_n = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy      = (state != IDLE);
    assign init_done = init_done_q;

endmodule

// File: tb/tb_dff_mem_arbiter.sv
// Directed self-checking bench for dff_mem_arbiter with a behavioural
// 16x8 DFF memory attached to the memory interface.
module tb_dff_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_we, b_valid, b_we;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_ready, b_ready, a_rsp_valid, b_rsp_valid;
    logic [7:0] a_rsp_rdata, b_rsp_rdata;
    logic       init_start, init_done, busy;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       mem_lr_n, mem_ce_n;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    dff_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .init_start(init_start), .init_done(init_done), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_lr_n(mem_lr_n), .mem_ce_n(mem_ce_n)
    );

    // Memory model: write on edge when lr_n low, data out only while ce_n low.
    always @(posedge clk) begin
        if (!mem_lr_n) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = (!mem_ce_n) ? mem[mem_addr] : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) chk("strobes_exclusive", {31'd0, (!mem_lr_n && !mem_ce_n)}, 32'd0);
        if (init_done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One full transaction on an idle DUT with only this port requesting.
    task automatic do_req(input bit port_b, input bit we, input logic [3:0] addr,
                          input logic [7:0] wdata);
        logic [7:0] exp;
        exp = we ? 8'h00 : mem[addr];
        if (port_b) begin
            b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        #1;
        chk("req_ready", port_b ? b_ready : a_ready, 1);
        chk("req_other_ready", port_b ? a_ready : b_ready, 0);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("acc_addr", mem_addr, addr);
        chk("acc_lr_n", mem_lr_n, we ? 0 : 1);
        chk("acc_ce_n", mem_ce_n, we ? 1 : 0);
        chk("acc_no_rsp", a_rsp_valid | b_rsp_valid, 0);
        step();
        #1;
        chk("rsp_valid", port_b ? b_rsp_valid : a_rsp_valid, 1);
        chk("rsp_other_valid", port_b ? a_rsp_valid : b_rsp_valid, 0);
        chk("rsp_rdata", port_b ? b_rsp_rdata : a_rsp_rdata, exp);
        step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        rst = 1'b1; init_start = 1'b0;
        a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_lr_n", mem_lr_n, 1);
        chk("rst_ce_n", mem_ce_n, 1);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rsp", {a_rsp_valid, b_rsp_valid}, 0);
        chk("rst_rdata", {a_rsp_rdata, b_rsp_rdata}, 0);
        chk("rst_init_done", init_done, 0);

        // Write then read back on A.
        do_req(1'b0, 1'b1, 4'd3, 8'h5A);
        do_req(1'b0, 1'b0, 4'd3, 8'h00);
        chk("a_read_5a", a_rsp_rdata, 8'h5A);

        // B write leaves last_grant = B so A wins the next tie.
        do_req(1'b1, 1'b1, 4'd7, 8'h11);

        // Both saturated with reads: A(addr1=0x11), B(addr2=0x12) alternate.
        a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd1;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 4'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_a_ready", a_ready, (k % 2 == 0) ? 1 : 0);
            chk("rr_b_ready", b_ready, (k % 2 == 0) ? 0 : 1);
            step(); #1;
            chk("rr_addr", mem_addr, (k % 2 == 0) ? 1 : 2);
            step(); #1;
            chk("rr_a_rsp", a_rsp_valid, (k % 2 == 0) ? 1 : 0);
            chk("rr_b_rsp", b_rsp_valid, (k % 2 == 0) ? 0 : 1);
            if (k % 2 == 0) chk("rr_a_rdata", a_rsp_rdata, 8'h11);
            else            chk("rr_b_rdata", b_rsp_rdata, 8'h12);
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // Fill with 0xFF, then clear; a_valid raised together with init_start.
        for (int i = 0; i < 16; i++) do_req(1'b0, 1'b1, 4'(i), 8'hFF);
        init_start = 1'b1; a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd5;
        #1;
        chk("init_vs_req_ready", a_ready, 0);
        step();
        init_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("init_busy", busy, 1);
            chk("init_addr", mem_addr, i);
            chk("init_lr_n", mem_lr_n, 0);
            chk("init_wdata", mem_wdata, 0);
            chk("init_ready", {a_ready, b_ready}, 0);
            chk("init_done_early", init_done, 0);
            step();
        end
        #1;
        chk("init_done_pulse", init_done, 1);
        chk("init_idle", busy, 0);
        chk("post_init_grant", a_ready, 1);
        step();
        a_valid = 1'b0;
        #1;
        chk("init_done_once", init_done, 0);
        chk("post_init_addr", mem_addr, 5);
        step(); #1;
        chk("post_init_rsp", a_rsp_valid, 1);
        chk("post_init_rdata", a_rsp_rdata, 0);
        step();
        for (int i = 0; i < 16; i++) chk("cleared", mem[i], 0);
        do_req(1'b1, 1'b0, 4'd12, 8'h00);
        chk("b_read_cleared", b_rsp_rdata, 0);

        // init_start during ACCESS is ignored.
        do_req(1'b1, 1'b1, 4'd0, 8'h3C);
        a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd0;
        #1;
        step();
        a_valid = 1'b0; init_start = 1'b1;
        #1;
        chk("acc_ce_n_read", mem_ce_n, 0);
        step();
        init_start = 1'b0;
        #1;
        chk("ign_rsp", a_rsp_valid, 1);
        chk("ign_rdata", a_rsp_rdata, 8'h3C);
        step(); #1;
        chk("ign_not_queued", busy, 0);

        // Reset during ACCESS of a write to addr 7 (old 0x11).
        do_req(1'b1, 1'b1, 4'd7, 8'h11);
        b_valid = 1'b1; b_we = 1'b1; b_addr = 4'd7; b_wdata = 8'h99;
        #1;
        step();
        b_valid = 1'b0; rst = 1'b1;
        #1;
        chk("pre_rst_lr_n", mem_lr_n, 0);
        step();
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_strobes", {mem_lr_n, mem_ce_n}, 2'b11);
        chk("arst_addr", mem_addr, 0);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_rsp", {a_rsp_valid, b_rsp_valid}, 0);
        chk("arst_rdata", {a_rsp_rdata, b_rsp_rdata}, 0);
        chk("arst_ready", {a_ready, b_ready}, 0);
        chk("arst_init_done", init_done, 0);
        chk("addr7_whole", (mem[7] == 8'h11 || mem[7] == 8'h99) ? 1 : 0, 1);
        step(); #1;
        chk("arst_no_late_rsp", b_rsp_valid, 0);

        // Reset during INIT at counter 5.
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #1;
        chk("irst_cnt5", mem_addr, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("irst_busy", busy, 0);
        chk("irst_done", init_done, 0);
        chk("irst_lr_n", mem_lr_n, 1);
        chk("irst_addr", mem_addr, 0);
        step(); #1;
        chk("irst_no_late_done", init_done, 0);
        chk("done_pulse_count", done_cnt, 1);

        // Normal operation resumes (addr 3 was cleared by the full sweep).
        do_req(1'b0, 1'b0, 4'd3, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
